// File: rtl/factorizer.sv
// Sequential prime factorizer: trial division by a restoring divider, emitting
// one factor per handshake. Define FACTORIZER_FAST_EN to skip even divisors > 2.
module factorizer #(
  parameter int WIDTH_LOG = 4,
  localparam int WIDTH = 1 << WIDTH_LOG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] n,
  input  logic             ack,
  output logic             ready,
  output logic             valid,
  output logic             last,
  output logic             error,
  output logic [WIDTH-1:0] res
);

  typedef enum logic [2:0] {READY, ERROR, CHECK, DIVIDE, EMIT} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d, div_q, div_d, rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH:0]       div_sq_q, div_sq_d;
  logic [WIDTH_LOG-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     res_d;
  logic                 ready_d, valid_d, last_d, error_d;

  // One restoring-division step: shift in the next dividend bit, try subtract.
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic             step_small;

  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, div_q};
    if (!diff[WIDTH]) begin
      rem_n = diff[WIDTH-1:0];
      quo_n = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = rem_sh[WIDTH-1:0];
      quo_n = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

`ifdef FACTORIZER_FAST_EN
  assign step_small = (div_q == WIDTH'(2));
`else
  assign step_small = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    div_d    = div_q;
    div_sq_d = div_sq_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    res_d    = res;
    ready_d  = ready;
    valid_d  = valid;
    last_d   = last;
    error_d  = error;
    case (state_q)
      READY, ERROR: begin
        if (go) begin
          if (n < WIDTH'(2)) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            state_d  = CHECK;
            m_d      = n;
            div_d    = WIDTH'(2);
            div_sq_d = (WIDTH+1)'(4);
            ready_d  = 1'b0;
            error_d  = 1'b0;
          end
        end
      end
      CHECK: begin
        if (div_sq_q > {1'b0, m_q}) begin
          if (m_q > WIDTH'(1)) begin
            state_d = EMIT;
            res_d   = m_q;
            last_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            state_d = READY;
            ready_d = 1'b1;
          end
        end else begin
          state_d = DIVIDE;
          rem_d   = '0;
          quo_d   = m_q;
          cnt_d   = '0;
        end
      end
      DIVIDE: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + WIDTH_LOG'(1);
        if (cnt_q == WIDTH_LOG'(WIDTH-1)) begin
          if (rem_n == '0) begin
            state_d = EMIT;
            res_d   = div_q;
            last_d  = 1'b0;
            valid_d = 1'b1;
            m_d     = quo_n;
          end else begin
            state_d = CHECK;
            // (d+1)^2 = d^2+2d+1 ; (d+2)^2 = d^2+4d+4
            if (step_small) begin
              div_d    = div_q + WIDTH'(1);
              div_sq_d = div_sq_q + {div_q, 1'b0} + (WIDTH+1)'(1);
            end else begin
              div_d    = div_q + WIDTH'(2);
              div_sq_d = div_sq_q + {div_q[WIDTH-2:0], 2'b00} + (WIDTH+1)'(4);
            end
          end
        end
      end
      EMIT: begin
        if (ack) begin
          valid_d = 1'b0;
          if (last) begin
            state_d = READY;
            ready_d = 1'b1;
            last_d  = 1'b0;
          end else begin
            state_d = CHECK;
          end
        end
      end
      default: begin
        state_d = READY;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= READY;
      m_q      <= '0;
      div_q    <= '0;
      div_sq_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      res      <= '0;
      ready    <= 1'b1;
      valid    <= 1'b0;
      last     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      div_q    <= div_d;
      div_sq_q <= div_sq_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      res      <= res_d;
      ready    <= ready_d;
      valid    <= valid_d;
      last     <= last_d;
      error    <= error_d;
    end
  end

endmodule

// File: doc/factorizer.md
FACTORIZER -- requirements
Module: factorizer

Interface
REQ-001 Parameter WIDTH_LOG, default 4, sets the operand width; WIDTH = 1 << WIDTH_LOG.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 go  input  1  start request; sampled only while ready=1.
REQ-005 n  input  WIDTH  unsigned number to factor; sampled with go.
REQ-006 ack  input  1  consumer accepts the factor on res; ignored while valid=0.
REQ-007 ready  output  1  idle, meaning the block accepts go; high in READY and ERROR states.
REQ-008 valid  output  1  res holds a factor awaiting ack.
REQ-009 last  output  1  qualifies valid, marking the final factor of n.
REQ-010 error  output  1  last request was rejected (n<2).
REQ-011 res  output  WIDTH  current prime factor.

Function
REQ-012 States SHALL be READY, ERROR, CHECK, DIVIDE, EMIT. All outputs SHALL be registered.
REQ-013 READY/ERROR with go=1: if n<2, next state ERROR (error=1, ready=1); else latch m=n, div=2, div_sq=4 and go to CHECK. ready SHALL drop the cycle after go is accepted.
REQ-014 go while ready=0 SHALL be ignored without side effects.
REQ-015 CHECK (1 cycle), when div_sq > m:
- if m>1, load res=m with last=1 and go to EMIT;
- otherwise go to READY.
REQ-016 CHECK, otherwise: start an internal restoring division m/div and go to DIVIDE.
REQ-017 DIVIDE SHALL last exactly WIDTH cycles and produce the quotient q and remainder r of the unsigned division.
REQ-018 At DIVIDE end, when r==0:
- res=div, last=0, m=q, div unchanged;
- go to EMIT.
REQ-019 At DIVIDE end, when r!=0: advance div per REQ-030/031, update div_sq = div_sq + 2*div + 1 (step 1) or + 4*div + 4 (step 2), and go to CHECK.
REQ-020 div_sq SHALL be WIDTH+1 bits wide so it never wraps for any WIDTH-bit m.
REQ-021 EMIT: valid=1 and res/last SHALL hold stable until ack=1. On ack, valid falls next cycle; next state is READY if last=1, else CHECK.
REQ-022 Factors SHALL be emitted in nondecreasing order, with repeats, and their product SHALL equal n.
REQ-023 A new go accepted in ERROR SHALL clear error the following cycle.
REQ-024 From go to the first valid, latency SHALL be 1 + (trials × (WIDTH+1)) cycles, where a trial is one CHECK plus one DIVIDE.

Reset
REQ-025 The reset value of every output SHALL be: ready=1, valid=0, last=0, error=0, res=0.
REQ-026 Internal state SHALL reset to READY with the divider idle.
REQ-027 Reset asserted mid-operation (DIVIDE or EMIT) SHALL abort immediately, discarding the pending factor.
REQ-028 After reset is released, the first rising edge SHALL be able to accept go.

Configuration
REQ-029 Macro FACTORIZER_FAST_EN selects the trial-divisor sequence.
REQ-030 FACTORIZER_FAST_EN defined: the sequence SHALL be 2, 3, 5, 7, 9, … (2→3, then +2).
REQ-031 FACTORIZER_FAST_EN undefined: the sequence SHALL be 2, 3, 4, 5, … (+1).
REQ-032 The emitted factor sequence SHALL be identical in both builds; only the trial count and latency differ.

Verification
REQ-033 n=12, ack held high → res 2, 2, 3; last=1 only on 3; ready returns high.
REQ-034 n=97 → single factor 97 with last=1; no earlier valid.
REQ-035 n=0, then n=1 → error=1, ready=1, valid never high; then n=6 → error clears, factors 2, 3.
REQ-036 WIDTH_LOG=4, n=65535 → 3, 5, 17, 257; n=65521 → single factor 65521 with no div_sq overflow; trial counts differ between FAST_EN builds while factors match.
REQ-037 ack held low 10 cycles in EMIT → valid/res/last stable throughout; go pulsed while busy is ignored.
REQ-038 rst pulsed during DIVIDE of n=221 → outputs reach reset values immediately; subsequent go with n=221 yields 13, 17.
